// File: rtl/scemi_out_pipe_get_mux_if.sv
// Bundle between the SceMi out-pipe proxies, the get mux and its consumer.
// LEVEL is present only when SCEMI_OUT_PIPE_LEVEL_EN is defined.
interface scemi_out_pipe_get_mux_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int DEPTH = 4
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*WIDTH-1:0] PXY_DATA;
  logic [NCH-1:0]       PXY_RDY;
  logic [NCH-1:0]       PXY_ACK;
  logic                 FLUSH;
  logic                 DATA_EN;
  logic [WIDTH-1:0]     DATA;
  logic [CW-1:0]        DATA_CH;
  logic                 DATA_RDY;
  logic                 ERR;

`ifdef SCEMI_OUT_PIPE_LEVEL_EN
  localparam int LW = $clog2(DEPTH) + 1;
  logic [NCH*LW-1:0]    LEVEL;

  modport master (
    output PXY_DATA, PXY_RDY, FLUSH, DATA_EN,
    input  PXY_ACK, DATA, DATA_CH, DATA_RDY, ERR, LEVEL
  );
  modport slave (
    input  PXY_DATA, PXY_RDY, FLUSH, DATA_EN,
    output PXY_ACK, DATA, DATA_CH, DATA_RDY, ERR, LEVEL
  );
`else
  modport master (
    output PXY_DATA, PXY_RDY, FLUSH, DATA_EN,
    input  PXY_ACK, DATA, DATA_CH, DATA_RDY, ERR
  );
  modport slave (
    input  PXY_DATA, PXY_RDY, FLUSH, DATA_EN,
    output PXY_ACK, DATA, DATA_CH, DATA_RDY, ERR
  );
`endif
endinterface

// File: rtl/scemi_out_pipe_get_mux.sv
// Per-channel prefetch FIFOs merged round-robin onto one registered get port.
// Define SCEMI_OUT_PIPE_LEVEL_EN to expose per-channel FIFO occupancy on LEVEL.
module scemi_out_pipe_get_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  scemi_out_pipe_get_mux_if.slave bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q    [NCH][DEPTH];
  logic [AW-1:0]    wr_ptr_q [NCH];
  logic [AW-1:0]    wr_ptr_d [NCH];
  logic [AW-1:0]    rd_ptr_q [NCH];
  logic [AW-1:0]    rd_ptr_d [NCH];
  logic [LW-1:0]    cnt_q    [NCH];
  logic [LW-1:0]    cnt_d    [NCH];

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [CW-1:0]    rr_q, rr_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;

  logic [NCH-1:0]   ack;
  logic [NCH-1:0]   pop;
  logic [CW-1:0]    grant;
  logic             found;
  logic             load;

  // Prefetch acks and round-robin search starting one past the last grant.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    ack   = '0;
    found = 1'b0;
    grant = '0;
    for (int c = 0; c < NCH; c++) begin
      ack[c] = bus.PXY_RDY[c] && (cnt_q[c] < LW'(DEPTH)) && !bus.FLUSH && !RST;
    end
    for (int i = 1; i <= NCH; i++) begin
      if (!found && (cnt_q[(int'(rr_q) + i) % NCH] != '0)) begin
        found = 1'b1;
        grant = CW'((int'(rr_q) + i) % NCH);
      end
    end
  end

  always_comb begin
    load   = !vld_q || bus.DATA_EN;
    pop    = '0;
    data_d = data_q;
    ch_d   = ch_q;
    rr_d   = rr_q;
    vld_d  = vld_q;
    err_d  = err_q || (bus.DATA_EN && !vld_q);

    if (bus.FLUSH) begin
      vld_d = 1'b0;
      rr_d  = CW'(NCH - 1);
    end else if (load) begin
      vld_d = found;
      if (found) begin
        data_d     = mem_q[grant][rd_ptr_q[grant]];
        ch_d       = grant;
        rr_d       = grant;
        pop[grant] = 1'b1;
      end
    end

    for (int c = 0; c < NCH; c++) begin
      if (bus.FLUSH) begin
        wr_ptr_d[c] = '0;
        rd_ptr_d[c] = '0;
        cnt_d[c]    = '0;
      end else begin
        wr_ptr_d[c] = wr_ptr_q[c] + AW'(ack[c]);
        rd_ptr_d[c] = rd_ptr_q[c] + AW'(pop[c]);
        cnt_d[c]    = cnt_q[c] + LW'(ack[c]) - LW'(pop[c]);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      data_q <= '0;
      ch_q   <= '0;
      rr_q   <= CW'(NCH - 1);
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
      data_q <= data_d;
      ch_q   <= ch_d;
      rr_q   <= rr_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
    end
  end

  // NOTE: storage is deliberately not reset; cnt/pointers define which
  // entries are valid, so resetting the array would only cost flops.
  always_ff @(posedge CLK) begin
    for (int c = 0; c < NCH; c++) begin
      if (ack[c]) mem_q[c][wr_ptr_q[c]] <= bus.PXY_DATA[c*WIDTH +: WIDTH];
    end
  end

  assign bus.PXY_ACK  = ack;
  assign bus.DATA     = RST ? '0 : data_q;
  assign bus.DATA_CH  = (RST || NCH == 1) ? '0 : ch_q;
  assign bus.DATA_RDY = vld_q && !RST;
  assign bus.ERR      = err_q;

`ifdef SCEMI_OUT_PIPE_LEVEL_EN
  for (genvar c = 0; c < NCH; c++) begin : g_level
    assign bus.LEVEL[c*LW +: LW] = cnt_q[c];
  end
`endif

endmodule
